truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//  Sequential upstream driver for the combinational 3-input function blocks
//  (A,B,C -> F).
//  - On start, drives every input code 000..111 in ascending order and waits
//    SETTLE cycles for each code.
//  - Samples F into an 8-bit truth table, indexed by the code.
//  - At the end, compares the table against EXPECTED and reports pass plus a
//    per-code mismatch mask.
//  Gives in-fabric self-check of a function block, replacing a hand-written
//  vector list.
// PARAMETERS
//  N_IN      3      number of function inputs; table width TW = 2**N_IN
//  SETTLE    1      cycles each code is held before F is sampled (>=1)
//  EXPECTED  8'hFE  golden table, bit i = F for code i (default F = A+B+C)
// PORTS
//  clk       in   1     rising-edge clock
//  rst_n     in   1     asynchronous active-low reset
//  start     in   1     scan request, sampled only in IDLE
//  f         in   1     output of the function under test
//  abc       out  N_IN  input code to the function block; abc[N_IN-1]=A, abc[0]=C
//  busy      out  1     high from the cycle after start is accepted until done
//  done      out  1     one-cycle pulse when the result is valid
//  pass      out  1     table_o == EXPECTED; held until the next start
//  table_o   out  TW    captured truth table; held until the next start
//  mismatch  out  TW    table_o ^ EXPECTED; held until the next start
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State=IDLE; abc, busy, done, pass, table_o, mismatch, idx and cnt all 0.
//   - Reset mid-scan aborts immediately; no done is produced.
//  FSM states: IDLE, DRIVE, SAMPLE, CHECK (all outputs registered)
//  IDLE
//   - start=1 -> DRIVE.
//   - Same edge: abc<=0, idx<=0, cnt<=SETTLE-1, table_o<=0, mismatch<=0,
//     pass<=0, busy<=1.
//  DRIVE
//   - cnt==0 -> SAMPLE; otherwise cnt--.
//  SAMPLE
//   - table_o[idx]<=f.
//   - If idx==TW-1 -> CHECK.
//   - Else idx++, abc<=idx+1, cnt<=SETTLE-1, -> DRIVE.
//  CHECK
//   - pass<=(table_o==EXPECTED), mismatch<=table_o^EXPECTED.
//   - done<=1, busy<=0, -> IDLE.
//   - done clears on the next edge.
//  Timing
//   - Each code is held SETTLE+1 cycles.
//   - done rises TW*(SETTLE+1)+1 edges after the start-accept edge
//     (17 at the defaults).
//   - Back-to-back scans: start is accepted in the cycle done is high
//     (state is already IDLE).
//  Boundaries
//   - start while busy is ignored; a level-held start gives exactly one scan
//     per IDLE visit.
//   - idx does not wrap past TW-1; abc holds TW-1 through CHECK and returns
//     to 0 only on the next start.
//   - f is sampled only in SAMPLE; glitches in DRIVE have no effect.
// STRUCTURE
//  - Shared header tts_defs.vh: state encodings (IDLE=2'd0, DRIVE=2'd1,
//    SAMPLE=2'd2, CHECK=2'd3) and the default EXPECTED constant.
//  - One sub-module, settle_timer: loadable down-counter with a zero flag,
//    width clog2(SETTLE)+1.
//  - Remainder (FSM, idx/abc register, table shift/compare) stays in the top.
// TESTING  (bench drives f from a reference model of abc unless noted)
//  1 Reset
//    - rst_n=0 -> abc=0, busy=0, done=0, pass=0, table_o=00, mismatch=00.
//  2 Pass case (f=A|B|C, SETTLE=1, 1-cycle start)
//    - abc steps 0..7, each held 2 cycles.
//    - done at edge 17; table_o=FE, pass=1, mismatch=00.
//  3 Fail case (f tied 0)
//    - table_o=00, pass=0, mismatch=FE.
//    - Then f=A|B|C with a second start -> table cleared, pass=1.
//  4 Start handling (start held high for 40 cycles)
//    - Exactly two done pulses, at edges 17 and 35.
//    - No restart while busy.
//  5 Reset mid-scan (rst_n low at edge 7 while busy)
//    - All outputs 0 immediately, before the next clock.
//    - After release: IDLE, no done.
//  6 Longer settle (SETTLE=3)
//    - Each code held 4 cycles; done at edge 33.
//    - f=A|B|C -> pass=1.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_CHECK  = 2'd3
  } tts_state_e;

  // Golden table for F = A|B|C; bit i is F for input code i.
  localparam logic [7:0] TTS_EXPECTED_DEFAULT = 8'hFE;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter; zero flags that the current code has settled.
module settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Drives every input code of a combinational block, captures F into a truth
// table and compares the result against a golden table.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned          N_IN     = 3,
  parameter int unsigned          SETTLE   = 1,
  parameter logic [2**N_IN-1:0]   EXPECTED = TTS_EXPECTED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 f,
  output logic [N_IN-1:0]      abc,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_o,
  output logic [2**N_IN-1:0]   mismatch
);

  localparam int unsigned    TW        = 2**N_IN;
  localparam int unsigned    CW        = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0]  SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TW - 1);

  tts_state_e      state, state_nxt;
  logic [N_IN-1:0] idx;
  logic            timer_load, timer_dec, timer_zero;

  settle_timer #(.W(CW)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_DRIVE;
          timer_load = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_zero) state_nxt = ST_SAMPLE;
        else            timer_dec = 1'b1;
      end
      ST_SAMPLE: begin
        if (idx == IDX_LAST) begin
          state_nxt = ST_CHECK;
        end else begin
          state_nxt  = ST_DRIVE;
          timer_load = 1'b1;
        end
      end
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // abc mirrors idx but stays at the last code until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abc      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      table_o  <= '0;
      mismatch <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            abc      <= '0;
            idx      <= '0;
            table_o  <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          table_o[idx] <= f;
          if (idx != IDX_LAST) begin
            idx <= idx + 1'b1;
            abc <= idx + 1'b1;
          end
        end
        ST_CHECK: begin
          pass     <= (table_o == EXPECTED);
          mismatch <= table_o ^ EXPECTED;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner at SETTLE=1 and SETTLE=3.
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start3;
  logic       f_mode;
  logic       f, f3;
  logic [2:0] abc, abc3;
  logic       busy, busy3, done, done3, pass, pass3;
  logic [7:0] table_o, table3, mismatch, mismatch3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Reference function block: F = A|B|C, or tied low when f_mode=0.
  assign f  = f_mode ? (|abc) : 1'b0;
  assign f3 = |abc3;

  truth_table_scanner #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hFE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f(f), .abc(abc), .busy(busy),
    .done(done), .pass(pass), .table_o(table_o), .mismatch(mismatch)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(3), .EXPECTED(8'hFE)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .f(f3), .abc(abc3), .busy(busy3),
    .done(done3), .pass(pass3), .table_o(table3), .mismatch(mismatch3)
  );

  logic [7:0] exp_tab;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle start, then wait for done; edge index relative to accept edge, -1 on timeout.
  task automatic run_scan(output int done_edge);
    done_edge = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done) begin
        done_edge = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; f_mode = 1'b1;
    tick(); tick();
    n_checks++; if (abc !== 3'd0)      begin n_fail++; $display("FAIL reset_abc: got %h expected 0", abc); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (pass !== 1'b0)     begin n_fail++; $display("FAIL reset_pass: got %b expected 0", pass); end
    n_checks++; if (table_o !== 8'h00) begin n_fail++; $display("FAIL reset_table: got %h expected 00", table_o); end
    n_checks++; if (mismatch !== 8'h00) begin n_fail++; $display("FAIL reset_mismatch: got %h expected 00", mismatch); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pass;
    int done_edge;
    int exp_abc;
    done_edge = -1;
    f_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy_accept: got %b expected 1", busy); end
    n_checks++; if (abc !== 3'd0)  begin n_fail++; $display("FAIL pass_abc_accept: got %h expected 0", abc); end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 17) begin
        exp_abc = (k / 2 > 7) ? 7 : k / 2;
        n_checks++;
        if (abc !== 3'(exp_abc)) begin
          n_fail++; $display("FAIL pass_abc_edge%0d: got %0d expected %0d", k, abc, exp_abc);
        end
      end
      if (done) begin done_edge = k; break; end
    end
    n_checks++; if (done_edge != 17)    begin n_fail++; $display("FAIL pass_done_edge: got %0d expected 17", done_edge); end
    n_checks++; if (table_o !== exp_tab) begin n_fail++; $display("FAIL pass_table: got %h expected %h", table_o, exp_tab); end
    n_checks++; if (pass !== 1'b1)      begin n_fail++; $display("FAIL pass_pass: got %b expected 1", pass); end
    n_checks++; if (mismatch !== 8'h00) begin n_fail++; $display("FAIL pass_mismatch: got %h expected 00", mismatch); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL pass_busy_done: got %b expected 0", busy); end
    tick();
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL pass_done_pulse: got %b expected 0", done); end
    n_checks++; if (abc !== 3'd7)       begin n_fail++; $display("FAIL pass_abc_hold: got %0d expected 7", abc); end
  endtask

  task automatic test_fail;
    int done_edge;
    f_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (table_o !== 8'h00) begin n_fail++; $display("FAIL fail_table_clear: got %h expected 00", table_o); end
    n_checks++; if (pass !== 1'b0)     begin n_fail++; $display("FAIL fail_pass_clear: got %b expected 0", pass); end
    done_edge = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done) begin done_edge = k; break; end
    end
    n_checks++; if (done_edge != 17)    begin n_fail++; $display("FAIL fail_done_edge: got %0d expected 17", done_edge); end
    n_checks++; if (table_o !== 8'h00)  begin n_fail++; $display("FAIL fail_table: got %h expected 00", table_o); end
    n_checks++; if (pass !== 1'b0)      begin n_fail++; $display("FAIL fail_pass: got %b expected 0", pass); end
    n_checks++; if (mismatch !== 8'hFE) begin n_fail++; $display("FAIL fail_mismatch: got %h expected FE", mismatch); end
    tick();
    f_mode = 1'b1;
    run_scan(done_edge);
    n_checks++; if (done_edge != 17)     begin n_fail++; $display("FAIL refail_done_edge: got %0d expected 17", done_edge); end
    n_checks++; if (table_o !== exp_tab) begin n_fail++; $display("FAIL refail_table: got %h expected %h", table_o, exp_tab); end
    n_checks++; if (pass !== 1'b1)       begin n_fail++; $display("FAIL refail_pass: got %b expected 1", pass); end
    n_checks++; if (mismatch !== 8'h00)  begin n_fail++; $display("FAIL refail_mismatch: got %h expected 00", mismatch); end
    tick();
  endtask

  task automatic test_start_held;
    int n_done;
    int edge_a, edge_b;
    bit drained;
    n_done = 0; edge_a = -1; edge_b = -1; drained = 1'b0;
    f_mode = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 10) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_busy_e10: got %b expected 1", busy); end
        n_checks++; if (abc !== 3'd5)  begin n_fail++; $display("FAIL held_abc_e10: got %0d expected 5", abc); end
      end
      if (done) begin
        if (n_done == 0) edge_a = k;
        if (n_done == 1) edge_b = k;
        n_done++;
      end
    end
    start = 1'b0;
    n_checks++; if (n_done != 2)  begin n_fail++; $display("FAIL held_done_count: got %0d expected 2", n_done); end
    n_checks++; if (edge_a != 17) begin n_fail++; $display("FAIL held_done_first: got %0d expected 17", edge_a); end
    n_checks++; if (edge_b != 35) begin n_fail++; $display("FAIL held_done_second: got %0d expected 35", edge_b); end
    // A third scan was accepted at edge 36 and completes at edge 53.
    for (int k = 40; k <= 80; k++) begin
      tick();
      if (done) begin drained = 1'b1; break; end
    end
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL held_drain: got %b expected 1", drained); end
    tick();
  endtask

  task automatic test_reset_mid;
    int n_done;
    logic any_busy;
    n_done = 0; any_busy = 1'b0;
    pass_prime: begin end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    n_checks++; if (abc !== 3'd3)  begin n_fail++; $display("FAIL mid_abc_before: got %0d expected 3", abc); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (abc !== 3'd0)      begin n_fail++; $display("FAIL mid_abc: got %h expected 0", abc); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL mid_done: got %b expected 0", done); end
    n_checks++; if (pass !== 1'b0)     begin n_fail++; $display("FAIL mid_pass: got %b expected 0", pass); end
    n_checks++; if (table_o !== 8'h00) begin n_fail++; $display("FAIL mid_table: got %h expected 00", table_o); end
    n_checks++; if (mismatch !== 8'h00) begin n_fail++; $display("FAIL mid_mismatch: got %h expected 00", mismatch); end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) n_done++;
      if (busy) any_busy = 1'b1;
    end
    n_checks++; if (n_done != 0)      begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", n_done); end
    n_checks++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got busy=%b expected 0", any_busy); end
    n_checks++; if (abc !== 3'd0)     begin n_fail++; $display("FAIL mid_abc_after: got %0d expected 0", abc); end
  endtask

  task automatic test_settle3;
    int done_edge;
    int exp_abc;
    done_edge = -1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k <= 33) begin
        exp_abc = (k / 4 > 7) ? 7 : k / 4;
        n_checks++;
        if (abc3 !== 3'(exp_abc)) begin
          n_fail++; $display("FAIL s3_abc_edge%0d: got %0d expected %0d", k, abc3, exp_abc);
        end
      end
      if (done3) begin done_edge = k; break; end
    end
    n_checks++; if (done_edge != 33)    begin n_fail++; $display("FAIL s3_done_edge: got %0d expected 33", done_edge); end
    n_checks++; if (table3 !== exp_tab) begin n_fail++; $display("FAIL s3_table: got %h expected %h", table3, exp_tab); end
    n_checks++; if (pass3 !== 1'b1)     begin n_fail++; $display("FAIL s3_pass: got %b expected 1", pass3); end
    n_checks++; if (mismatch3 !== 8'h00) begin n_fail++; $display("FAIL s3_mismatch: got %h expected 00", mismatch3); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_tab[i] = (i != 0);
    test_reset();
    test_pass();
    test_fail();
    test_start_held();
    test_reset_mid();
    test_settle3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
